// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID buffer, flush, misalign and timeout faults
module fetch_stage #(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        flush,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {ISSUE, WAIT, FULL, FAULT} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic        discard, discard_nx;
  logic [31:0] req_pc, req_pc_nx;
  logic        valid_nx, pc_en_nx, fault_nx;
  logic [31:0] out_nx, ipc_nx;
  logic [1:0]  cause_nx;

  // Request is combinational so an ISSUE cycle and its strobe coincide.
  assign imem_req  = !rst && (state == ISSUE) && (pc_in[1:0] == 2'b00);
  assign imem_addr = imem_req ? pc_in : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE;
      cnt         <= '0;
      discard     <= 1'b0;
      req_pc      <= 32'h0;
      instr_valid <= 1'b0;
      instr_out   <= RESET_INSTR;
      instr_pc    <= 32'h0;
      pc_en       <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      discard     <= discard_nx;
      req_pc      <= req_pc_nx;
      instr_valid <= valid_nx;
      instr_out   <= out_nx;
      instr_pc    <= ipc_nx;
      pc_en       <= pc_en_nx;
      fetch_fault <= fault_nx;
      fault_cause <= cause_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    discard_nx = discard;
    req_pc_nx  = req_pc;
    valid_nx   = instr_valid;
    out_nx     = instr_out;
    ipc_nx     = instr_pc;
    pc_en_nx   = 1'b0;
    fault_nx   = fetch_fault;
    cause_nx   = fault_cause;
    case (state)
      ISSUE: begin
        if (pc_in[1:0] != 2'b00) begin
          state_nx = FAULT;
          fault_nx = 1'b1;
          cause_nx = 2'b01;
        end else begin
          req_pc_nx = pc_in;
          cnt_nx    = '0;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt + CW'(1);
        if (imem_ack) begin
          discard_nx = 1'b0;
          if (discard || flush) begin
            state_nx = ISSUE;
          end else begin
            valid_nx = 1'b1;
            out_nx   = imem_rdata;
            ipc_nx   = req_pc;
            pc_en_nx = 1'b1;
            state_nx = FULL;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nx = FAULT;
          fault_nx = 1'b1;
          cause_nx = 2'b10;
        end else if (flush) begin
          // Response still owed by memory; remember to drop it.
          discard_nx = 1'b1;
        end
      end
      FULL: begin
        if (flush) begin
          valid_nx = 1'b0;
          out_nx   = RESET_INSTR;
          state_nx = ISSUE;
        end else if (id_ready) begin
          valid_nx = 1'b0;
          state_nx = ISSUE;
        end
      end
      FAULT: begin
        valid_nx = 1'b0;
        fault_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int          TO = 16;
  localparam logic [31:0] RI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_en, imem_req, imem_ack, flush, id_ready, instr_valid, fetch_fault;
  logic [31:0] pc_in, imem_addr, imem_rdata, instr_out, instr_pc;
  logic [1:0]  fault_cause;

  fetch_stage #(.TIMEOUT(TO), .RESET_INSTR(RI)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack), .flush(flush),
    .id_ready(id_ready), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] pc; logic ack; logic [31:0] rdata; logic fl; logic rdy;
    logic req; logic [31:0] addr; logic pcen; logic valid; logic [31:0] iout; logic [31:0] ipc;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [31:0] pc, input logic ack, input logic [31:0] rdata,
                     input logic fl, input logic rdy, input logic req, input logic [31:0] addr,
                     input logic pcen, input logic valid, input logic [31:0] iout,
                     input logic [31:0] ipc);
    vec_t v;
    v = '{pc, ack, rdata, fl, rdy, req, addr, pcen, valid, iout, ipc};
    vt.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; pc_in = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; flush = 1'b0; id_ready = 1'b0;
    next_cycle();
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk32("rst_iout", instr_out, RI);
    chk32("rst_ipc", instr_pc, 32'h0);
    chk1("rst_pcen", pc_en, 1'b0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk32("rst_cause", {30'h0, fault_cause}, 32'h0);
    rst = 1'b0;
    #0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] pc_reg, exp_pc, paddr;
  int          due, accepts;
  bit          pending, prev_flush, prev_pcen;

  initial begin
    // Cycle-accurate vectors: sequential fetch, back-pressure, FULL flush, WAIT flush.
    add(32'h0,   0, 0, 0, 1,  1, 32'h0,   0, 0, RI, 32'h0);
    add(32'h0,   1, 32'hA000_0000, 0, 1,  0, 0, 0, 0, RI, 32'h0);
    add(32'h0,   0, 0, 0, 1,  0, 0, 1, 1, 32'hA000_0000, 32'h0);
    add(32'h4,   0, 0, 0, 1,  1, 32'h4,   0, 0, 32'hA000_0000, 32'h0);
    add(32'h4,   1, 32'hA000_0001, 0, 1,  0, 0, 0, 0, 32'hA000_0000, 32'h0);
    add(32'h4,   0, 0, 0, 1,  0, 0, 1, 1, 32'hA000_0001, 32'h4);
    add(32'h8,   0, 0, 0, 1,  1, 32'h8,   0, 0, 32'hA000_0001, 32'h4);
    add(32'h8,   1, 32'hA000_0002, 0, 1,  0, 0, 0, 0, 32'hA000_0001, 32'h4);
    add(32'h8,   0, 0, 0, 1,  0, 0, 1, 1, 32'hA000_0002, 32'h8);
    add(32'hC,   0, 0, 0, 1,  1, 32'hC,   0, 0, 32'hA000_0002, 32'h8);
    add(32'hC,   1, 32'hA000_0003, 0, 1,  0, 0, 0, 0, 32'hA000_0002, 32'h8);
    add(32'hC,   0, 0, 0, 1,  0, 0, 1, 1, 32'hA000_0003, 32'hC);
    add(32'h10,  0, 0, 0, 0,  1, 32'h10,  0, 0, 32'hA000_0003, 32'hC);
    add(32'h10,  1, 32'hDEAD_BEEF, 0, 0,  0, 0, 0, 0, 32'hA000_0003, 32'hC);
    add(32'h10,  0, 0, 0, 0,  0, 0, 1, 1, 32'hDEAD_BEEF, 32'h10);
    for (int i = 0; i < 4; i++) add(32'h14, 0, 0, 0, 0,  0, 0, 0, 1, 32'hDEAD_BEEF, 32'h10);
    add(32'h14,  0, 0, 0, 1,  0, 0, 0, 1, 32'hDEAD_BEEF, 32'h10);
    add(32'h40,  0, 0, 0, 1,  1, 32'h40,  0, 0, 32'hDEAD_BEEF, 32'h10);
    add(32'h40,  1, 32'hC0DE_0040, 0, 0,  0, 0, 0, 0, 32'hDEAD_BEEF, 32'h10);
    add(32'h200, 0, 0, 1, 1,  0, 0, 1, 1, 32'hC0DE_0040, 32'h40);
    add(32'h200, 0, 0, 0, 0,  1, 32'h200, 0, 0, RI, 32'h40);
    add(32'h200, 1, 32'h22, 0, 0,  0, 0, 0, 0, RI, 32'h40);
    add(32'h204, 0, 0, 0, 1,  0, 0, 1, 1, 32'h22, 32'h200);
    add(32'h20,  0, 0, 0, 1,  1, 32'h20,  0, 0, 32'h22, 32'h200);
    add(32'h100, 0, 0, 1, 1,  0, 0, 0, 0, 32'h22, 32'h200);
    add(32'h100, 0, 0, 0, 1,  0, 0, 0, 0, 32'h22, 32'h200);
    add(32'h100, 0, 0, 0, 1,  0, 0, 0, 0, 32'h22, 32'h200);
    add(32'h100, 1, 32'hBAD0_BAD0, 0, 1,  0, 0, 0, 0, 32'h22, 32'h200);
    add(32'h100, 0, 0, 0, 1,  1, 32'h100, 0, 0, 32'h22, 32'h200);
    add(32'h100, 1, 32'h11, 0, 1,  0, 0, 0, 0, 32'h22, 32'h200);
    add(32'h104, 0, 0, 0, 1,  0, 0, 1, 1, 32'h11, 32'h100);

    reset_dut();
    foreach (vt[i]) begin
      pc_in = vt[i].pc; imem_ack = vt[i].ack; imem_rdata = vt[i].rdata;
      flush = vt[i].fl; id_ready = vt[i].rdy;
      #2;
      chk1($sformatf("v%0d_req", i), imem_req, vt[i].req);
      if (vt[i].req) chk32($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      chk1($sformatf("v%0d_pcen", i), pc_en, vt[i].pcen);
      chk1($sformatf("v%0d_valid", i), instr_valid, vt[i].valid);
      chk32($sformatf("v%0d_iout", i), instr_out, vt[i].iout);
      chk32($sformatf("v%0d_ipc", i), instr_pc, vt[i].ipc);
      chk1($sformatf("v%0d_fault", i), fetch_fault, 1'b0);
      next_cycle();
    end

    // Misaligned PC: no request, sticky fault until reset.
    reset_dut();
    pc_in = 32'h6; id_ready = 1'b1;
    #2;
    chk1("mis_req", imem_req, 1'b0);
    next_cycle();
    pc_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 1);
      #2;
      chk1("mis_hold_req", imem_req, 1'b0);
      chk1("mis_hold_fault", fetch_fault, 1'b1);
      chk32("mis_hold_cause", {30'h0, fault_cause}, 32'h1);
      chk1("mis_hold_valid", instr_valid, 1'b0);
      chk1("mis_hold_pcen", pc_en, 1'b0);
      next_cycle();
    end
    imem_ack = 1'b0;
    reset_dut();
    #2;
    chk1("mis_clr_fault", fetch_fault, 1'b0);
    chk1("mis_clr_req", imem_req, 1'b1);

    // Ack on the last WAIT cycle before the timeout is still accepted.
    reset_dut();
    pc_in = 32'h30; id_ready = 1'b0;
    next_cycle();
    for (int i = 1; i <= TO; i++) begin
      imem_ack = (i == TO); imem_rdata = 32'h77;
      next_cycle();
    end
    imem_ack = 1'b0;
    #2;
    chk1("late_ack_valid", instr_valid, 1'b1);
    chk32("late_ack_iout", instr_out, 32'h77);
    chk1("late_ack_fault", fetch_fault, 1'b0);

    // Memory timeout, then an ack two cycles later is ignored.
    reset_dut();
    pc_in = 32'h30;
    #2;
    chk1("to_req", imem_req, 1'b1);
    chk32("to_addr", imem_addr, 32'h30);
    next_cycle();
    for (int i = 1; i <= TO; i++) begin
      #2;
      chk1("to_wait_fault", fetch_fault, 1'b0);
      chk1("to_wait_req", imem_req, 1'b0);
      next_cycle();
    end
    #2;
    chk1("to_fault", fetch_fault, 1'b1);
    chk32("to_cause", {30'h0, fault_cause}, 32'h2);
    next_cycle();
    imem_ack = 1'b1; imem_rdata = 32'h55;
    next_cycle();
    imem_ack = 1'b0;
    #2;
    chk1("to_ign_valid", instr_valid, 1'b0);
    chk1("to_ign_pcen", pc_en, 1'b0);
    chk1("to_ign_req", imem_req, 1'b0);
    chk32("to_ign_cause", {30'h0, fault_cause}, 32'h2);

    // Random traffic against a pc register, a delayed-ack memory and an in-order scoreboard.
    reset_dut();
    pc_reg = 32'h0; exp_pc = 32'h0; pending = 0; prev_flush = 0; prev_pcen = 0;
    due = 0; accepts = 0; paddr = 32'h0;
    for (int t = 0; t < 4000; t++) begin
      if (!prev_flush && prev_pcen) pc_reg = pc_reg + 32'd4;
      flush = ($urandom_range(0, 24) == 0);
      if (flush) pc_reg = 32'($urandom_range(0, 16383)) << 2;
      pc_in = pc_reg;
      id_ready = ($urandom_range(0, 2) != 0);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (pending && due == t) begin
        imem_ack = 1'b1;
        imem_rdata = mem(paddr);
        pending = 0;
      end
      #2;
      if (imem_req) begin
        chk1("rnd_outstanding", pending, 1'b0);
        chk32("rnd_addr", imem_addr, pc_reg);
        pending = 1;
        paddr = imem_addr;
        due = t + int'($urandom_range(1, 4));
      end
      if (instr_valid && id_ready && !flush) begin
        chk32("rnd_ipc", instr_pc, exp_pc);
        chk32("rnd_data", instr_out, mem(instr_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (flush) exp_pc = pc_reg;
      prev_flush = flush;
      prev_pcen = pc_en;
      next_cycle();
    end
    flush = 1'b0;
    chk1("rnd_no_fault", fetch_fault, 1'b0);
    chk1("rnd_progress", accepts > 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
